// File: rtl/riscv_id_pipe_if.sv
// Decode-stage bus: fetch-side handshake, register-file write port and the
// registered decode result. The slave modport is the decode stage's view.
interface riscv_id_pipe_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instruction;
  logic [XLEN-1:0] pc;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_rd;
  logic [2:0]      out_funct3;
  logic            out_alt;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_rs2;
  logic [XLEN-1:0] out_pc;
  logic            out_exception;

  modport slave (
    input  in_valid, instruction, pc, wb_en, wb_rd, wb_data, flush, out_ready,
    output in_ready, out_valid, out_rd, out_funct3, out_alt, out_a, out_b,
           out_imm, out_rs2, out_pc, out_exception
  );

  modport master (
    output in_valid, instruction, pc, wb_en, wb_rd, wb_data, flush, out_ready,
    input  in_ready, out_valid, out_rd, out_funct3, out_alt, out_a, out_b,
           out_imm, out_rs2, out_pc, out_exception
  );
endinterface

// File: rtl/riscv_id_pipe.sv
// RV32I instruction decode stage: 32-entry register file with optional
// writeback forwarding, immediate generation, operand selection and a single
// output register slot with valid/ready handshake and flush.
module riscv_id_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter bit          BYPASS = 1'b1
) (
  input logic            clk,
  input logic            rst,
  riscv_id_pipe_if.slave bus
);

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef enum logic [1:0] {
    A_ZERO,
    A_RS1,
    A_PC
  } a_sel_e;

  typedef enum logic {
    B_IMM,
    B_RS2
  } b_sel_e;

  logic [XLEN-1:0]    rf_q [32];

  logic [31:0]        ins;
  logic [2:0]         funct3;
  logic [4:0]         rs1_idx;
  logic [4:0]         rs2_idx;
  logic [XLEN-1:0]    rs1_val;
  logic [XLEN-1:0]    rs2_val;

  imm_fmt_e           imm_fmt;
  a_sel_e             a_sel;
  b_sel_e             b_sel;
  logic               has_rd;
  logic               illegal;
  logic signed [31:0] imm32;

  logic               in_ready;
  logic               accept;

  logic               valid_d,  valid_q;
  logic [4:0]         rd_d,     rd_q;
  logic [2:0]         funct3_d, funct3_q;
  logic               alt_d,    alt_q;
  logic               exc_d,    exc_q;
  logic [XLEN-1:0]    a_d,      a_q;
  logic [XLEN-1:0]    b_d,      b_q;
  logic [XLEN-1:0]    imm_d,    imm_q;
  logic [XLEN-1:0]    rs2_d,    rs2_q;
  logic [XLEN-1:0]    pc_d,     pc_q;

  assign ins     = bus.instruction;
  assign funct3  = ins[14:12];
  assign rs1_idx = ins[19:15];
  assign rs2_idx = ins[24:20];

  assign in_ready = !valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready && !bus.flush;

  // Register file write port; x0 is never written and never read back.
  always_ff @(posedge clk) begin
    if (bus.wb_en && (bus.wb_rd != 5'd0)) begin
      rf_q[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Register read ports with optional same-cycle forwarding of the writeback.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1_idx != 5'd0) begin
      if (BYPASS && bus.wb_en && (bus.wb_rd == rs1_idx)) rs1_val = bus.wb_data;
      else                                               rs1_val = rf_q[rs1_idx];
    end
    if (rs2_idx != 5'd0) begin
      if (BYPASS && bus.wb_en && (bus.wb_rd == rs2_idx)) rs2_val = bus.wb_data;
      else                                               rs2_val = rf_q[rs2_idx];
    end
  end

  // Opcode classification: immediate format, operand sources, legality.
  // All legal opcodes end in 2'b11, so the default arm also traps bits 1:0.
  always_comb begin
    imm_fmt = IMM_NONE;
    a_sel   = A_ZERO;
    b_sel   = B_IMM;
    has_rd  = 1'b1;
    illegal = 1'b0;
    case (ins[6:0])
      OPC_OP_IMM: begin
        imm_fmt = IMM_I;
        a_sel   = A_RS1;
      end
      OPC_LOAD: begin
        imm_fmt = IMM_I;
        a_sel   = A_RS1;
        illegal = funct3 inside {3'b011, 3'b110, 3'b111};
      end
      OPC_JALR: begin
        imm_fmt = IMM_I;
        a_sel   = A_RS1;
        illegal = (funct3 != 3'b000);
      end
      OPC_OP: begin
        a_sel = A_RS1;
        b_sel = B_RS2;
      end
      OPC_STORE: begin
        imm_fmt = IMM_S;
        a_sel   = A_RS1;
        has_rd  = 1'b0;
        illegal = (funct3 > 3'b010);
      end
      OPC_BRANCH: begin
        imm_fmt = IMM_B;
        a_sel   = A_RS1;
        b_sel   = B_RS2;
        has_rd  = 1'b0;
        illegal = funct3 inside {3'b010, 3'b011};
      end
      OPC_LUI: begin
        imm_fmt = IMM_U;
      end
      OPC_AUIPC: begin
        imm_fmt = IMM_U;
        a_sel   = A_PC;
      end
      OPC_JAL: begin
        imm_fmt = IMM_J;
        a_sel   = A_PC;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // Immediate assembly as a signed 32-bit value, then sign-extended to XLEN.
  always_comb begin
    imm32 = '0;
    case (imm_fmt)
      IMM_I:   imm32 = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm32 = {ins[31:12], 12'b0};
      IMM_J:   imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm_d = XLEN'(imm32);
  end

  // Operand muxing and the remaining next-state values for the output slot.
  always_comb begin
    a_d = '0;
    case (a_sel)
      A_RS1:   a_d = rs1_val;
      A_PC:    a_d = bus.pc;
      default: a_d = '0;
    endcase
    b_d      = (b_sel == B_RS2) ? rs2_val : imm_d;
    exc_d    = illegal;
    rd_d     = (has_rd && !illegal) ? ins[11:7] : 5'd0;
    funct3_d = funct3;
    alt_d    = ins[30];
    rs2_d    = rs2_val;
    pc_d     = bus.pc;
  end

  // Output-slot occupancy: flush dominates, then a new accept, then a drain.
  always_comb begin
    valid_d = valid_q;
    if (bus.flush)          valid_d = 1'b0;
    else if (accept)        valid_d = 1'b1;
    else if (bus.out_ready) valid_d = 1'b0;
  end

  // Output slot; payload loads only on accept so it is stable while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      rd_q     <= '0;
      funct3_q <= '0;
      alt_q    <= 1'b0;
      exc_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      rs2_q    <= '0;
      pc_q     <= '0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        rd_q     <= rd_d;
        funct3_q <= funct3_d;
        alt_q    <= alt_d;
        exc_q    <= exc_d;
        a_q      <= a_d;
        b_q      <= b_d;
        imm_q    <= imm_d;
        rs2_q    <= rs2_d;
        pc_q     <= pc_d;
      end
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = valid_q;
  assign bus.out_rd        = rd_q;
  assign bus.out_funct3    = funct3_q;
  assign bus.out_alt       = alt_q;
  assign bus.out_exception = exc_q;
  assign bus.out_a         = a_q;
  assign bus.out_b         = b_q;
  assign bus.out_imm       = imm_q;
  assign bus.out_rs2       = rs2_q;
  assign bus.out_pc        = pc_q;

endmodule

// File: tb/tb_riscv_id_pipe.sv
`timescale 1ns/1ps
// Bench for riscv_id_pipe: three instances (32-bit with forwarding, 32-bit
// without, 64-bit with forwarding) share one stimulus stream and are compared
// against an arithmetic decode model and a one-slot occupancy model.
module tb_riscv_id_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_id_pipe_if #(.XLEN(32)) if_a ();
  riscv_id_pipe_if #(.XLEN(32)) if_b ();
  riscv_id_pipe_if #(.XLEN(64)) if_c ();

  riscv_id_pipe #(.XLEN(32), .BYPASS(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  riscv_id_pipe #(.XLEN(32), .BYPASS(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  riscv_id_pipe #(.XLEN(64), .BYPASS(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  typedef struct packed {
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        alt;
    logic        exc;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] imm;
    logic [63:0] rs2;
    logic [63:0] pc;
  } res_t;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  logic        s_in_valid, s_wb_en, s_flush, s_out_ready;
  logic [31:0] s_ins;
  logic [63:0] s_pc, s_wb_data;
  logic [4:0]  s_wb_rd;

  logic [63:0] rf_m [32];
  logic        exp_valid;
  res_t        exp_r [3];
  int unsigned xl [3] = '{32, 32, 64};
  bit          byp [3] = '{1'b1, 1'b0, 1'b1};
  logic [6:0]  opc_tab [9] = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic drive();
    if_a.in_valid = s_in_valid;   if_b.in_valid = s_in_valid;   if_c.in_valid = s_in_valid;
    if_a.instruction = s_ins;     if_b.instruction = s_ins;     if_c.instruction = s_ins;
    if_a.pc = s_pc[31:0];         if_b.pc = s_pc[31:0];         if_c.pc = s_pc;
    if_a.wb_en = s_wb_en;         if_b.wb_en = s_wb_en;         if_c.wb_en = s_wb_en;
    if_a.wb_rd = s_wb_rd;         if_b.wb_rd = s_wb_rd;         if_c.wb_rd = s_wb_rd;
    if_a.wb_data = s_wb_data[31:0]; if_b.wb_data = s_wb_data[31:0]; if_c.wb_data = s_wb_data;
    if_a.flush = s_flush;         if_b.flush = s_flush;         if_c.flush = s_flush;
    if_a.out_ready = s_out_ready; if_b.out_ready = s_out_ready; if_c.out_ready = s_out_ready;
  endtask

  function automatic logic get_valid(input int k);
    case (k)
      0:       return if_a.out_valid;
      1:       return if_b.out_valid;
      default: return if_c.out_valid;
    endcase
  endfunction

  function automatic logic get_ready(input int k);
    case (k)
      0:       return if_a.in_ready;
      1:       return if_b.in_ready;
      default: return if_c.in_ready;
    endcase
  endfunction

  function automatic res_t obs(input int k);
    res_t r;
    case (k)
      0: begin
        r.rd = if_a.out_rd; r.f3 = if_a.out_funct3; r.alt = if_a.out_alt; r.exc = if_a.out_exception;
        r.a = 64'(if_a.out_a); r.b = 64'(if_a.out_b); r.imm = 64'(if_a.out_imm);
        r.rs2 = 64'(if_a.out_rs2); r.pc = 64'(if_a.out_pc);
      end
      1: begin
        r.rd = if_b.out_rd; r.f3 = if_b.out_funct3; r.alt = if_b.out_alt; r.exc = if_b.out_exception;
        r.a = 64'(if_b.out_a); r.b = 64'(if_b.out_b); r.imm = 64'(if_b.out_imm);
        r.rs2 = 64'(if_b.out_rs2); r.pc = 64'(if_b.out_pc);
      end
      default: begin
        r.rd = if_c.out_rd; r.f3 = if_c.out_funct3; r.alt = if_c.out_alt; r.exc = if_c.out_exception;
        r.a = if_c.out_a; r.b = if_c.out_b; r.imm = if_c.out_imm;
        r.rs2 = if_c.out_rs2; r.pc = if_c.out_pc;
      end
    endcase
    return r;
  endfunction

  function automatic logic [63:0] rd_reg(input logic [4:0] idx, input bit bp);
    if (idx == 5'd0) return 64'd0;
    if (bp && s_wb_en && (s_wb_rd == idx)) return s_wb_data;
    return rf_m[idx];
  endfunction

  // Reference decode of the current stimulus for a given width and forwarding mode.
  function automatic res_t model(input int unsigned xlen, input bit bp);
    res_t        r;
    longint      si, s_i, s_s, s_t, s_u;
    logic [63:0] m, rs1v, rs2v, imm, a, b;
    logic [6:0]  opc;
    logic [2:0]  f3;
    bit          legal, no_rd;
    m    = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    si   = longint'($signed(s_ins));
    s_i  = si >>> 20;
    s_s  = si >>> 25;
    s_t  = si >>> 31;
    s_u  = si >>> 12;
    rs1v = rd_reg(s_ins[19:15], bp);
    rs2v = rd_reg(s_ins[24:20], bp);
    opc  = s_ins[6:0];
    f3   = s_ins[14:12];
    legal = 1'b1; no_rd = 1'b0; imm = '0; a = '0; b = '0;
    case (opc)
      7'h13: begin imm = s_i; a = rs1v; b = imm; end
      7'h03: begin imm = s_i; a = rs1v; b = imm; legal = !(f3 == 3'd3 || f3 >= 3'd6); end
      7'h67: begin imm = s_i; a = rs1v; b = imm; legal = (f3 == 3'd0); end
      7'h33: begin a = rs1v; b = rs2v; end
      7'h23: begin
        imm = s_s * 32 + longint'(s_ins[11:7]);
        a = rs1v; b = imm; no_rd = 1'b1; legal = (f3 <= 3'd2);
      end
      7'h63: begin
        imm = s_t * 4096 + longint'(s_ins[7]) * 2048 + longint'(s_ins[30:25]) * 32
              + longint'(s_ins[11:8]) * 2;
        a = rs1v; b = rs2v; no_rd = 1'b1; legal = (f3 != 3'd2 && f3 != 3'd3);
      end
      7'h37: begin imm = s_u * 4096; a = '0; b = imm; end
      7'h17: begin imm = s_u * 4096; a = s_pc; b = imm; end
      7'h6F: begin
        imm = s_t * 1048576 + longint'(s_ins[19:12]) * 4096 + longint'(s_ins[20]) * 2048
              + longint'(s_ins[30:21]) * 2;
        a = s_pc; b = imm;
      end
      default: legal = 1'b0;
    endcase
    r.rd  = (!legal || no_rd) ? 5'd0 : s_ins[11:7];
    r.f3  = f3;
    r.alt = s_ins[30];
    r.exc = !legal;
    r.a   = a & m;
    r.b   = b & m;
    r.imm = imm & m;
    r.rs2 = rs2v & m;
    r.pc  = s_pc & m;
    return r;
  endfunction

  task automatic check_outputs();
    res_t o, e;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("out_valid[%0d]", k), 64'(get_valid(k)), 64'(exp_valid));
      if (exp_valid) begin
        o = obs(k);
        e = exp_r[k];
        chk($sformatf("rd[%0d]", k),  64'(o.rd),  64'(e.rd));
        chk($sformatf("f3[%0d]", k),  64'(o.f3),  64'(e.f3));
        chk($sformatf("alt[%0d]", k), 64'(o.alt), 64'(e.alt));
        chk($sformatf("exc[%0d]", k), 64'(o.exc), 64'(e.exc));
        chk($sformatf("pc[%0d]", k),  o.pc,  e.pc);
        chk($sformatf("rs2[%0d]", k), o.rs2, e.rs2);
        if (!e.exc) begin
          chk($sformatf("a[%0d]", k),   o.a,   e.a);
          chk($sformatf("b[%0d]", k),   o.b,   e.b);
          chk($sformatf("imm[%0d]", k), o.imm, e.imm);
        end
      end
    end
  endtask

  // One clock: check in_ready before the edge, advance the model, check after.
  task automatic step();
    logic rdy_e, acc;
    drive();
    #1;
    rdy_e = !exp_valid || s_out_ready;
    for (int k = 0; k < 3; k++) chk($sformatf("in_ready[%0d]", k), 64'(get_ready(k)), 64'(rdy_e));
    acc = s_in_valid && rdy_e && !s_flush;
    if (acc) for (int k = 0; k < 3; k++) exp_r[k] = model(xl[k], byp[k]);
    exp_valid = s_flush ? 1'b0 : acc ? 1'b1 : s_out_ready ? 1'b0 : exp_valid;
    if (s_wb_en && s_wb_rd != 5'd0) rf_m[s_wb_rd] = s_wb_data;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic reset_check(input string tag);
    res_t o;
    for (int k = 0; k < 3; k++) begin
      o = obs(k);
      chk($sformatf("%s_valid[%0d]", tag, k), 64'(get_valid(k)), 64'd0);
      chk($sformatf("%s_ready[%0d]", tag, k), 64'(get_ready(k)), 64'd1);
      chk($sformatf("%s_exc[%0d]", tag, k), 64'(o.exc), 64'd0);
      chk($sformatf("%s_rd[%0d]", tag, k),  64'(o.rd),  64'd0);
      chk($sformatf("%s_f3[%0d]", tag, k),  64'(o.f3),  64'd0);
      chk($sformatf("%s_alt[%0d]", tag, k), 64'(o.alt), 64'd0);
      chk($sformatf("%s_a[%0d]", tag, k),   o.a,   64'd0);
      chk($sformatf("%s_b[%0d]", tag, k),   o.b,   64'd0);
      chk($sformatf("%s_imm[%0d]", tag, k), o.imm, 64'd0);
      chk($sformatf("%s_rs2[%0d]", tag, k), o.rs2, 64'd0);
      chk($sformatf("%s_pc[%0d]", tag, k),  o.pc,  64'd0);
    end
  endtask

  task automatic gen_ins();
    logic [31:0] x;
    int unsigned r;
    x = $urandom();
    r = $urandom_range(0, 9);
    if (r < 9) s_ins = {x[31:7], opc_tab[r]};
    else       s_ins = x;
  endtask

  initial begin
    s_in_valid = 1'b0; s_wb_en = 1'b0; s_flush = 1'b0; s_out_ready = 1'b1;
    s_ins = '0; s_pc = '0; s_wb_data = '0; s_wb_rd = '0;
    exp_valid = 1'b0;
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    rst = 1'b1;
    drive();
    #2 rst = 1'b0;
    #1 reset_check("por");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    // Populate every register before any read depends on it.
    for (int i = 1; i < 32; i++) begin
      s_wb_en = 1'b1; s_wb_rd = 5'(i); s_wb_data = {$urandom(), $urandom()};
      step();
    end
    s_wb_en = 1'b0;

    // li t0,42
    s_ins = 32'h02A00293; s_pc = 64'h1000; s_in_valid = 1'b1; s_out_ready = 1'b1;
    step();
    chk("li_valid", 64'(if_a.out_valid), 64'd1);
    chk("li_rd",    64'(if_a.out_rd), 64'd5);
    chk("li_a",     64'(if_a.out_a), 64'd0);
    chk("li_b",     64'(if_a.out_b), 64'd42);
    chk("li_f3",    64'(if_a.out_funct3), 64'd0);
    chk("li_exc",   64'(if_a.out_exception), 64'd0);

    // addi x7,x6,-1 with and without a same-cycle write to x6
    s_in_valid = 1'b0; s_wb_en = 1'b1; s_wb_rd = 5'd6; s_wb_data = 64'd100;
    step();
    s_wb_en = 1'b0; s_in_valid = 1'b1; s_ins = 32'hFFF30393;
    step();
    chk("addi_a",   64'(if_a.out_a), 64'd100);
    chk("addi_b",   64'(if_a.out_b), 64'hFFFF_FFFF);
    chk("addi_imm", 64'(if_a.out_imm), 64'hFFFF_FFFF);
    chk("addi_b64", if_c.out_b, 64'hFFFF_FFFF_FFFF_FFFF);
    s_wb_en = 1'b1; s_wb_rd = 5'd6; s_wb_data = 64'd7;
    step();
    chk("byp_a_on",  64'(if_a.out_a), 64'd7);
    chk("byp_a_off", 64'(if_b.out_a), 64'd100);
    chk("byp_a_64",  if_c.out_a, 64'd7);
    s_wb_en = 1'b0;

    // Stall three cycles, then release into the next instruction
    s_out_ready = 1'b0; s_ins = 32'h00500413;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_ready", 64'(if_a.in_ready), 64'd0);
      chk("hold_rd",    64'(if_a.out_rd), 64'd7);
      chk("hold_a_on",  64'(if_a.out_a), 64'd7);
      chk("hold_a_off", 64'(if_b.out_a), 64'd100);
    end
    s_out_ready = 1'b1;
    step();
    chk("release_rd", 64'(if_a.out_rd), 64'd8);
    chk("release_b",  64'(if_a.out_b), 64'd5);

    // All-zero word is illegal
    s_ins = 32'h0000_0000;
    step();
    chk("zero_exc",   64'(if_a.out_exception), 64'd1);
    chk("zero_rd",    64'(if_a.out_rd), 64'd0);
    chk("zero_valid", 64'(if_a.out_valid), 64'd1);

    // Flush with a concurrent offer
    s_flush = 1'b1; s_ins = 32'h02A00293;
    step();
    chk("flush_valid", 64'(if_a.out_valid), 64'd0);
    s_flush = 1'b0; s_in_valid = 1'b0;
    step();
    chk("flush_nocap", 64'(if_a.out_valid), 64'd0);

    // 64-bit sign extension of U and J immediates
    s_in_valid = 1'b1; s_ins = 32'h800000B7;
    step();
    chk("lui64_a", if_c.out_a, 64'd0);
    chk("lui64_b", if_c.out_b, 64'hFFFF_FFFF_8000_0000);
    s_ins = 32'hFFDFF0EF; s_pc = 64'h100;
    step();
    chk("jal64_a", if_c.out_a, 64'h100);
    chk("jal64_b", if_c.out_b, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("jal32_b", 64'(if_a.out_b), 64'hFFFF_FFFC);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      s_in_valid  = ($urandom_range(0, 9) < 7);
      s_out_ready = ($urandom_range(0, 9) < 7);
      s_flush     = ($urandom_range(0, 19) == 0);
      s_wb_en     = $urandom_range(0, 1) == 1;
      s_wb_rd     = 5'($urandom());
      s_wb_data   = {$urandom(), $urandom()};
      s_pc        = {$urandom(), $urandom()};
      gen_ins();
      step();
    end

    // Reset in the middle of a held result
    s_in_valid = 1'b1; s_out_ready = 1'b0; s_flush = 1'b0; s_wb_en = 1'b0;
    s_ins = 32'h40000293; s_pc = 64'h2000;
    step();
    #1 rst = 1'b0;
    #1 reset_check("midrst");
    exp_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    s_out_ready = 1'b1;
    step();
    chk("postrst_rd",  64'(if_a.out_rd), 64'd5);
    chk("postrst_imm", 64'(if_a.out_imm), 64'd1024);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/riscv_id_pipe.md
RISCV_ID_PIPE -- requirements
Module: riscv_id_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter BYPASS, default 1, enables writeback-to-read forwarding.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  instruction/pc offered.
REQ-006 in_ready  output  1  stage can accept an instruction this cycle.
REQ-007 instruction  input  32  raw RV32I encoding.
REQ-008 pc  input  XLEN  address of instruction.
REQ-009 wb_en, wb_rd, wb_data  input  1/5/XLEN  register-file write port.
REQ-010 flush  input  1  discard held output.
REQ-011 out_valid  output  1  decoded result held.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_rd, out_funct3, out_alt  output  5/3/1  destination, funct3, instruction bit 30.
REQ-014 out_a, out_b, out_imm, out_rs2  output  XLEN each  operands, sign-extended immediate, raw rs2 value.
REQ-015 out_pc  output  XLEN  pc of held instruction.
REQ-016 out_exception  output  1  illegal instruction flag.

Function
REQ-017 Register file SHALL be 32 x XLEN; x0 reads 0; writes to x0 ignored; write on rising edge when wb_en.
REQ-018 in_ready SHALL equal !out_valid || out_ready (combinational).
REQ-019 Accept = in_valid && in_ready; on accept, all out_* SHALL load from the decode of that instruction at the same edge; latency 1 cycle.
REQ-020 out_valid SHALL set on accept, clear when out_ready && !accept, and hold otherwise; held outputs SHALL stay stable while out_valid && !out_ready.
REQ-021 flush SHALL clear out_valid at the edge and block any accept that cycle (flush wins).
REQ-022 Immediates SHALL be decoded per format (I, S, B, U, J) and sign-extended to XLEN; R-type out_imm = 0.
REQ-023 Operand selection: OP-IMM/LOAD/JALR: a=rs1, b=imm; OP: a=rs1, b=rs2; STORE: a=rs1, b=imm; BRANCH: a=rs1, b=rs2; LUI: a=0, b=imm; AUIPC/JAL: a=pc, b=imm.
REQ-024 out_rd SHALL be 0 for STORE and BRANCH; instruction bits 11:7 otherwise.
REQ-025 With BYPASS=1, a read of rs1/rs2 matching a nonzero wb_rd with wb_en SHALL return wb_data in the same cycle; with BYPASS=0, the old value.
REQ-026 out_exception SHALL be 1 when bits 1:0 != 2'b11, opcode is outside {OP-IMM, OP, LUI, AUIPC, JAL, JALR, LOAD, STORE, BRANCH}, or funct3 is reserved for JALR/BRANCH/LOAD/STORE; when set, out_rd=0 and the result is still delivered with out_valid.

Reset
REQ-027 While rst=0: out_valid=0, out_exception=0, out_rd=0, out_funct3=0, out_alt=0, all XLEN outputs=0, immediately without waiting for clk.
REQ-028 Register file contents (except x0) SHALL be undefined after reset; benches SHALL write before reading.
REQ-029 Reset asserted mid-transfer SHALL drop the held result; in_ready=1 on the first edge after release.

Verification
REQ-030 Reset, then instruction=32'h02A00293 (li t0,42), in_valid=1, out_ready=1 -> next cycle out_valid=1, rd=5, a=0, b=42, funct3=0, exception=0.
REQ-031 wb x6=100; addi x7,x6,-1 -> a=100, b=32'hFFFFFFFF, imm=-1; with wb_en x6=7 in the accept cycle -> a=7 if BYPASS=1, 100 if BYPASS=0.
REQ-032 Hold out_ready=0 with out_valid=1 for 3 cycles -> in_ready=0, outputs unchanged; release -> next instruction loads in the same cycle.
REQ-033 instruction=32'h00000000 -> out_exception=1, out_rd=0, out_valid=1.
REQ-034 Assert flush together with in_valid -> out_valid=0 next cycle and the instruction is not captured.
REQ-035 XLEN=64: lui x1,0x80000 -> b=64'hFFFFFFFF80000000; jal x1,-4 at pc=0x100 -> a=0x100, b=-4 sign-extended.
